// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if -- request/response bundle between control_unit and alu_sequencer.
//   start      : one-cycle request to run an operation
//   op         : 00 add, 01 sub, 10 mul, 11 div
//   operand_a  : first operand, unsigned
//   operand_b  : second operand, unsigned
//   busy       : operation in progress
//   done       : one-cycle pulse, result/flags valid
//   result     : sum/difference, product (low half) or quotient
//   remainder  : division remainder, 0 for other ops
//   overflow   : result did not fit in WIDTH bits
//   div_zero   : division by zero requested
// master = requester (control_unit), slave = alu_sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, remainder, overflow, div_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, remainder, overflow, div_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer -- multi-cycle unsigned ALU: add/sub in one pass, shift-add
// multiply and restoring divide at one bit per cycle.
//   clock : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : alu_sequencer_if.slave (start/op/operands in, busy/done/result/flags out)
// Add/sub and divide-by-zero go IDLE->FINISH; mul/div go IDLE->ITER for WIDTH
// cycles, then FINISH. FINISH registers result/flags and pulses done, so done is
// high while the FSM is already back in IDLE and can accept the next start.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input logic            clock,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  state_t state_q, state_d;
  op_t    op_q;
  op_t    op_in;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   shreg_q;   // mul: multiplier shifting right; div: dividend in, quotient out
  logic [WIDTH-1:0]   rem_q;     // div partial remainder
  logic [2*WIDTH-1:0] mcand_q;   // mul: multiplicand shifting left
  logic [2*WIDTH-1:0] acc_q;     // mul: product accumulator
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0] result_q, remainder_q;
  logic             overflow_q, div_zero_q, done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_in   = op_t'(bus.op);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (op_in)
            OP_ADD, OP_SUB: state_d = FINISH;
            OP_MUL:         state_d = ITER;
            OP_DIV:         state_d = (bus.operand_b == '0) ? FINISH : ITER;
            default:        state_d = IDLE;
          endcase
        end
      end
      ITER:    if (cnt_q == LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arithmetic helpers
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    // Restoring step: bring next dividend bit into the partial remainder and
    // subtract the divisor only if it fits.
    div_shift = {rem_q, shreg_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[WIDTH-1:0] - b_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q       <= op_in;
            a_q        <= bus.operand_a;
            b_q        <= bus.operand_b;
            mcand_q    <= {{WIDTH{1'b0}}, bus.operand_a};
            shreg_q    <= (op_in == OP_DIV) ? bus.operand_a : bus.operand_b;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
        ITER: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q == OP_MUL) begin
            if (shreg_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            shreg_q <= shreg_q >> 1;
          end else begin
            rem_q   <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            shreg_q <= {shreg_q[WIDTH-2:0], div_ge};
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          case (op_q)
            OP_ADD: begin
              result_q    <= sum[WIDTH-1:0];
              remainder_q <= '0;
              overflow_q  <= sum[WIDTH];
            end
            OP_SUB: begin
              result_q    <= diff;
              remainder_q <= '0;
              overflow_q  <= (a_q < b_q);
            end
            OP_MUL: begin
              result_q    <= acc_q[WIDTH-1:0];
              remainder_q <= '0;
              overflow_q  <= |acc_q[2*WIDTH-1:WIDTH];
            end
            default: begin
              if (b_q == '0) begin
                result_q    <= '0;
                remainder_q <= '0;
                div_zero_q  <= 1'b1;
              end else begin
                result_q    <= shreg_q;
                remainder_q <= rem_q;
              end
              overflow_q <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = remainder_q;
  assign bus.overflow  = overflow_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- directed vectors for alu_sequencer; expected responses are
// queued at issue time and checked by an independent monitor on each done pulse.
module tb_alu_sequencer;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         ov;
    logic         dz;
    int unsigned  cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned busy_cnt;
  exp_t sb[$];

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request at the current (negedge) time; accept edge is the next posedge.
  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input string name,
                       input logic [W-1:0] er, input logic [W-1:0] erem,
                       input logic eov, input logic edz, input int unsigned lat);
    exp_t e;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    if (push) begin
      e.res = er; e.rem = erem; e.ov = eov; e.dz = edz;
      e.cyc = cyc + 1 + lat; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    // Inputs changing after acceptance must not disturb the operation.
    bus.operand_a = ~a;
    bus.operand_b = 16'h0000;
    bus.op        = ~op;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string name, input logic [W-1:0] er, input logic [W-1:0] erem,
                       input logic eov, input logic edz, input int unsigned lat);
    @(negedge clk);
    drive(op, a, b, 1'b1, name, er, erem, eov, edz, lat);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},      {31'd0, bus.busy},     0);
    check({tag, "_done"},      {31'd0, bus.done},     0);
    check({tag, "_result"},    {16'd0, bus.result},   0);
    check({tag, "_remainder"}, {16'd0, bus.remainder}, 0);
    check({tag, "_overflow"},  {31'd0, bus.overflow}, 0);
    check({tag, "_div_zero"},  {31'd0, bus.div_zero}, 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"},    {16'd0, bus.result},    {16'd0, e.res});
        check({e.name, "_remainder"}, {16'd0, bus.remainder}, {16'd0, e.rem});
        check({e.name, "_overflow"},  {31'd0, bus.overflow},  {31'd0, e.ov});
        check({e.name, "_div_zero"},  {31'd0, bus.div_zero},  {31'd0, e.dz});
        check({e.name, "_done_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // First start on the first edge after reset deasserts.
    rst = 1'b0;
    drive(2'b00, 16'd3, 16'd2, 1'b1, "add_3_2", 16'd5, 16'd0, 1'b0, 1'b0, 1);
    drain();
    issue(2'b00, 16'd65535, 16'd1, "add_wrap", 16'd0, 16'd0, 1'b1, 1'b0, 1);
    drain();
    issue(2'b01, 16'd2, 16'd3, "sub_borrow", 16'd65535, 16'd0, 1'b1, 1'b0, 1);
    drain();
    issue(2'b01, 16'd10, 16'd3, "sub_10_3", 16'd7, 16'd0, 1'b0, 1'b0, 1);
    drain();

    // Div 7/4 with a start attempt at cycle 5 that must be ignored.
    @(negedge clk);
    drive(2'b11, 16'd7, 16'd4, 1'b1, "div_7_4", 16'd1, 16'd3, 1'b0, 1'b0, 17);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 16'd5; bus.operand_b = 16'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
    end
    check("div_busy_cycles", busy_cnt, 17);
    drain();

    issue(2'b11, 16'd7, 16'd0, "div_zero", 16'd0, 16'd0, 1'b0, 1'b1, 1);
    drain();
    issue(2'b11, 16'd1000, 16'd7, "div_1000_7", 16'd142, 16'd6, 1'b0, 1'b0, 17);
    drain();
    issue(2'b11, 16'd65535, 16'd65535, "div_max", 16'd1, 16'd0, 1'b0, 1'b0, 17);
    drain();
    issue(2'b10, 16'd300, 16'd300, "mul_300_300", 16'd24464, 16'd0, 1'b1, 1'b0, 17);
    drain();
    issue(2'b10, 16'd89, 16'd7, "mul_89_7", 16'd623, 16'd0, 1'b0, 1'b0, 17);
    drain();
    issue(2'b10, 16'd65535, 16'd65535, "mul_max", 16'd1, 16'd0, 1'b1, 1'b0, 17);
    drain();

    // Back-to-back: second start lands in the done cycle of the add.
    issue(2'b00, 16'd100, 16'd200, "b2b_add", 16'd300, 16'd0, 1'b0, 1'b0, 1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_done_high", {31'd0, bus.done}, 1);
    drive(2'b10, 16'd89, 16'd7, 1'b1, "b2b_mul", 16'd623, 16'd0, 1'b0, 1'b0, 17);
    drain();

    // Reset at cycle 8 of a mul aborts it with no done pulse.
    @(negedge clk);
    drive(2'b10, 16'd300, 16'd300, 1'b0, "aborted", '0, '0, 1'b0, 1'b0, 17);
    repeat (8) @(negedge clk);
    check("abort_busy_before", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("abort");
    rst = 1'b0;
    issue(2'b10, 16'd12, 16'd11, "after_reset_mul", 16'd132, 16'd0, 1'b0, 1'b0, 17);
    drain();
    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
